// File: rtl/mem_loader.sv
`timescale 1ns/1ps
// mem_loader
// ----------
// Assembles a host byte stream into 64-bit little-endian words and writes
// them to consecutive data-memory addresses. Load parameters (base address
// and word count) are captured when a start request is accepted in IDLE.
//
// Optional feature: define MEM_LOADER_CHKSUM_EN to add the 8-bit chksum
// output. It holds the modulo-256 sum of every byte accepted since the last
// start accept.
//
// Parameters:
//   ADDR_STRIDE  byte-address increment applied after each completed write
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous reset, active low
//   start       begin a load (sampled only in IDLE)
//   base_addr   byte address of the first word (captured on start)
//   word_count  number of 64-bit words to write (captured on start)
//   s_valid     host byte valid
//   s_data      host byte payload
//   s_ready     loader accepts s_data this cycle
//   mem_ready   memory write port granted to the loader
//   mem_we      memory write request
//   mem_addr    memory write byte address
//   mem_wdata   memory write data
//   busy        high from start accept until the done pulse
//   done        one-cycle completion pulse
//   chksum      byte checksum (only with MEM_LOADER_CHKSUM_EN)
module mem_loader #(
  parameter int ADDR_STRIDE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done
`ifdef MEM_LOADER_CHKSUM_EN
  ,
  output logic [7:0]  chksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] STRIDE = 16'(ADDR_STRIDE);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] words_q, words_d;
`ifdef MEM_LOADER_CHKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      byte_cnt_q <= '0;
      words_q    <= '0;
`ifdef MEM_LOADER_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byte_cnt_q <= byte_cnt_d;
      words_q    <= words_d;
`ifdef MEM_LOADER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byte_cnt_d = byte_cnt_q;
    words_d    = words_q;
`ifdef MEM_LOADER_CHKSUM_EN
    chk_d      = chk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MEM_LOADER_CHKSUM_EN
          chk_d = '0;
`endif
          if (word_count != 16'd0) begin
            state_d    = FILL;
            addr_d     = base_addr;
            words_d    = word_count;
            byte_cnt_d = '0;
          end else begin
            // Empty load: report completion without touching memory.
            state_d = DONE;
          end
        end
      end
      FILL: begin
        // s_ready is high throughout FILL, so s_valid alone means accept.
        if (s_valid) begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = s_data;
          byte_cnt_d = 3'(byte_cnt_q + 3'd1);
`ifdef MEM_LOADER_CHKSUM_EN
          chk_d = 8'(chk_q + s_data);
`endif
          if (byte_cnt_q == 3'd7) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          addr_d     = 16'(addr_q + STRIDE);
          words_d    = 16'(words_q - 16'd1);
          byte_cnt_d = '0;
          state_d    = (words_q == 16'd1) ? DONE : FILL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    s_ready = (state_q == FILL);
    mem_we  = (state_q == WRITE);
    busy    = (state_q == FILL) || (state_q == WRITE);
    done    = (state_q == DONE);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef MEM_LOADER_CHKSUM_EN
  assign chksum    = chk_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for mem_loader: directed loads, expected writes are
// queued by the stimulus and checked by an independent write monitor.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic        mem_ready = 1'b1;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        busy;
  logic        done;
`ifdef MEM_LOADER_CHKSUM_EN
  logic [7:0]  chksum;
`endif

  mem_loader #(.ADDR_STRIDE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done)
`ifdef MEM_LOADER_CHKSUM_EN
    ,
    .chksum     (chksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Scoreboard of expected memory writes
  typedef struct packed {
    logic [15:0] a;
    logic [63:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int  nwr = 0;

  logic        prev_we = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [63:0] prev_data = '0;

  // Write monitor: checks every completed write against the queue and
  // checks that a stalled write keeps its request/address/data steady.
  always @(negedge clk) begin
    if (reset) begin
      if (prev_we && !prev_rdy) begin
        check("hold_we", {63'd0, mem_we}, 64'd1);
        check("hold_addr", {48'd0, mem_addr}, {48'd0, prev_addr});
        check("hold_data", mem_wdata, prev_data);
      end
      if (mem_we && mem_ready) begin
        nwr++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {48'd0, mem_addr}, {48'd0, mon_e.a});
          check("wr_data", mem_wdata, mon_e.d);
        end
      end
    end
    prev_we   <= mem_we && reset;
    prev_rdy  <= mem_ready;
    prev_addr <= mem_addr;
    prev_data <= mem_wdata;
  end

  logic [7:0] src [64];
  logic [7:0] last_ck;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load. Bytes come from src[0..nbytes-1]; gaps inserts idle
  // cycles on s_valid; stall holds mem_ready low for that many WRITE cycles
  // of the first word; poke asserts a stray start mid-load.
  task automatic run_load(input logic [15:0] base, input logic [15:0] cnt,
                          input int nbytes, input bit gaps, input int stall,
                          input bit poke, output int delay, output bit sr_seen);
    int c0;
    int idx;
    int st;
    bit got;
    bit acc;
    idx = 0;
    st = stall;
    got = 0;
    sr_seen = 0;
    delay = -1;
    base_addr = base;
    word_count = cnt;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    base_addr = 16'hAAAA;
    word_count = 16'h0005;
    check("busy_after_start", {63'd0, busy}, {63'd0, (cnt != 16'd0)});
    for (int n = 0; n < 2000; n++) begin
      if (done) begin
        delay = cyc - c0;
        got = 1;
        check("busy_at_done", {63'd0, busy}, 64'd0);
`ifdef MEM_LOADER_CHKSUM_EN
        last_ck = chksum;
`endif
        break;
      end
      if (s_ready) sr_seen = 1;
      start = poke && (n == 4);
      s_valid = (idx < nbytes) && (!gaps || (n % 3 != 1));
      s_data = (idx < nbytes) ? src[idx] : 8'hEE;
      if (mem_we && st > 0) begin
        mem_ready = 1'b0;
        st--;
      end else begin
        mem_ready = 1'b1;
      end
      acc = s_valid && s_ready;
      tick();
      if (acc) idx++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    mem_ready = 1'b1;
    if (!got) begin
      n_total++;
      $display("FAIL done_timeout: got no done pulse, required done");
    end
    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic push(input logic [15:0] a, input logic [63:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int  dly;
    bit  srs;
    int  w0;
    bit  we_seen;

    // Reset state
    tick();
    tick();
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b1;

    // Two words, continuous stream, stray start mid-load; start on the
    // first edge after reset release.
    for (int i = 0; i < 16; i++) src[i] = 8'(i + 1);
    push(16'h0100, 64'h0807060504030201);
    push(16'h0108, 64'h100F0E0D0C0B0A09);
    run_load(16'h0100, 16'd2, 16, 0, 0, 1, dly, srs);
    check("latency_2words", 64'(dly), 64'd19);

    // One word with a 5-cycle memory stall
    for (int i = 0; i < 8; i++) src[i] = 8'(8'hA0 + i);
    push(16'h1234, 64'hA7A6A5A4A3A2A1A0);
    w0 = nwr;
    run_load(16'h1234, 16'd1, 8, 0, 5, 0, dly, srs);
    check("stall_one_write", 64'(nwr - w0), 64'd1);
    check("stall_latency", 64'(dly), 64'd15);

    // Zero-word load
    w0 = nwr;
    run_load(16'h5555, 16'd0, 0, 0, 0, 0, dly, srs);
    check("zero_latency", 64'(dly), 64'd1);
    check("zero_no_sready", {63'd0, srs}, 64'd0);
    check("zero_no_writes", 64'(nwr - w0), 64'd0);

    // Address wrap with gaps in the byte stream
    for (int i = 0; i < 8; i++) src[i] = 8'(8'h11 + i);
    for (int i = 0; i < 8; i++) src[8 + i] = 8'(8'h21 + i);
    push(16'hFFF8, 64'h1817161514131211);
    push(16'h0000, 64'h2827262524232221);
    run_load(16'hFFF8, 16'd2, 16, 1, 0, 0, dly, srs);

    // Reset mid-FILL after 3 bytes
    base_addr = 16'h0200;
    word_count = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h55;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    s_valid = 1'b0;
    check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("mid_rst_addr", {48'd0, mem_addr}, 64'd0);
    check("mid_rst_wdata", mem_wdata, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_we) we_seen = 1;
      tick();
    end
    check("no_we_after_rst", {63'd0, we_seen}, 64'd0);
    for (int i = 0; i < 8; i++) src[i] = 8'(8'hC0 + i);
    push(16'h0300, 64'hC7C6C5C4C3C2C1C0);
    run_load(16'h0300, 16'd1, 8, 0, 0, 0, dly, srs);
    check("after_rst_latency", 64'(dly), 64'd10);

`ifdef MEM_LOADER_CHKSUM_EN
    src[0] = 8'hFF;
    src[1] = 8'h01;
    for (int i = 2; i < 8; i++) src[i] = 8'h00;
    push(16'h0040, 64'h00000000000001FF);
    run_load(16'h0040, 16'd1, 8, 0, 0, 0, dly, srs);
    check("chksum_wrap", {56'd0, last_ck}, 64'h00);
    for (int i = 0; i < 8; i++) src[i] = 8'h10;
    push(16'h0050, 64'h1010101010101010);
    run_load(16'h0050, 16'd1, 8, 0, 0, 0, dly, srs);
    check("chksum_x10", {56'd0, last_ck}, 64'h80);
    check("chksum_stable", {56'd0, chksum}, 64'h80);
`endif

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
